// File: rtl/sevenseg_scan_counter.sv
// sevenseg_scan_counter: multi-digit up/down counter with load, tick prescaler and seven-segment scan driver
//   clk       in   clock
//   rstn      in   synchronous active-low reset
//   en        in   count enable (prescaler and counter hold when low)
//   up        in   count direction, 1 = increment
//   load      in   synchronous load strobe, wins over a tick
//   load_val  in   value loaded on load, one nibble per digit
//   value     out  registered count, digit 0 in the low nibble
//   wrap      out  one-cycle pulse when the whole count rolls over
//   segments  out  registered glyph g..a of the selected digit
//   digit_sel out  registered one-hot digit enable
// Define SEVENSEG_HEX_EN for radix-16 digits; otherwise digits are decimal.
module sevenseg_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4,
    parameter int SCAN_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_sel
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
`ifdef SEVENSEG_HEX_EN
    localparam logic [3:0] RMAX = 4'hF;
`else
    localparam logic [3:0] RMAX = 4'd9;
`endif

    logic [PW-1:0]         pre_cnt;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  carry;
    logic [4*DIGITS-1:0]   stepped;
    logic [4*DIGITS-1:0]   loaded;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        glyph = 7'h00;
        case (n)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
`ifdef SEVENSEG_HEX_EN
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
`endif
            default: glyph = 7'h00;
        endcase
    endfunction

    assign tick = en && pre_cnt == PRE_MAX;

    // Ripple the +/-1 through the digits; carry left set means every digit rolled over.
    always_comb begin
        carry   = 1'b1;
        stepped = value;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (up) begin
                    stepped[4*i +: 4] = value[4*i +: 4] == RMAX ? 4'd0 : value[4*i +: 4] + 4'd1;
                    carry             = value[4*i +: 4] == RMAX;
                end else begin
                    stepped[4*i +: 4] = value[4*i +: 4] == 4'd0 ? RMAX : value[4*i +: 4] - 4'd1;
                    carry             = value[4*i +: 4] == 4'd0;
                end
            end
        end
    end

    // Decimal digits saturate out-of-range load nibbles so value never holds a non-digit.
    always_comb begin
        loaded = load_val;
        for (int i = 0; i < DIGITS; i++)
            loaded[4*i +: 4] = load_val[4*i +: 4] > RMAX ? RMAX : load_val[4*i +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            value     <= '0;
            wrap      <= 1'b0;
            pre_cnt   <= '0;
            scan_cnt  <= '0;
            idx       <= '0;
            digit_sel <= DIGITS'(1);
            segments  <= 7'h3F;
        end else begin
            digit_sel <= DIGITS'(1) << idx;
            segments  <= glyph(value[4*idx +: 4]);
            scan_cnt  <= scan_cnt == SCAN_MAX ? '0 : scan_cnt + 1'b1;
            if (scan_cnt == SCAN_MAX)
                idx <= idx == IDX_MAX ? '0 : idx + 1'b1;
            wrap <= !load && tick && carry;
            if (load) begin
                value   <= loaded;
                pre_cnt <= '0;
            end else if (en) begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                if (tick)
                    value <= stepped;
            end
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_counter.sv
// tb_sevenseg_scan_counter: scoreboard bench comparing the counter/scan driver against an integer reference model
module tb_sevenseg_scan_counter;
    localparam int D = 2;
    localparam int P = 4;
    localparam int S = 2;
`ifdef SEVENSEG_HEX_EN
    localparam int R = 16;
    localparam logic [6:0] GL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`else
    localparam int R = 10;
    localparam logic [6:0] GL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`endif
    localparam int MOD = R ** D;

    logic clk = 1'b0;
    logic rstn, en, up, load;
    logic [4*D-1:0] load_val;
    logic [4*D-1:0] value;
    logic           wrap;
    logic [6:0]     segments;
    logic [D-1:0]   digit_sel;

    typedef struct {
        logic [4*D-1:0] value;
        logic           wrap;
        logic [6:0]     seg;
        logic [D-1:0]   sel;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int m_val = 0;
    int m_pre = 0;
    int m_n = 0;
    logic m_wrap = 1'b0;

    sevenseg_scan_counter #(.DIGITS(D), .PRESCALE(P), .SCAN_DIV(S)) dut (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value), .wrap(wrap), .segments(segments), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    function automatic int digit_of(input int v, input int i);
        return (v / (R ** i)) % R;
    endfunction

    function automatic logic [4*D-1:0] to_bus(input int v);
        logic [4*D-1:0] b = '0;
        for (int i = 0; i < D; i++) b[4*i +: 4] = 4'(digit_of(v, i));
        return b;
    endfunction

    function automatic int from_load(input logic [4*D-1:0] lv);
        int v = 0;
        for (int i = 0; i < D; i++) v += (int'(lv[4*i +: 4]) > R - 1 ? R - 1 : int'(lv[4*i +: 4])) * (R ** i);
        return v;
    endfunction

    // Apply inputs for the coming edge and queue what the outputs must be after it.
    task automatic step(input logic r, input logic e, input logic u, input logic l, input logic [4*D-1:0] lv);
        exp_t x;
        int cur;
        rstn = r; en = e; up = u; load = l; load_val = lv;
        if (!r) begin
            m_val = 0; m_pre = 0; m_n = 0; m_wrap = 1'b0;
            x.sel = D'(1);
            x.seg = 7'h3F;
        end else begin
            cur   = (m_n / S) % D;
            x.sel = D'(1) << cur;
            x.seg = GL[digit_of(m_val, cur)];
            m_n++;
            m_wrap = 1'b0;
            if (l) begin
                m_val = from_load(lv);
                m_pre = 0;
            end else if (e) begin
                if (m_pre == P - 1) begin
                    m_pre = 0;
                    m_wrap = u ? m_val == MOD - 1 : m_val == 0;
                    m_val  = u ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
                end else begin
                    m_pre++;
                end
            end
        end
        x.value = to_bus(m_val);
        x.wrap  = m_wrap;
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("value", 32'(value), 32'(x.value));
                chk("wrap", 32'(wrap), 32'(x.wrap));
                chk("segments", 32'(segments), 32'(x.seg));
                chk("digit_sel", 32'(digit_sel), 32'(x.sel));
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, '0);
        step(0, 1, 1, 0, '0);
        repeat (40) step(1, 1, 1, 0, '0);
        step(1, 0, 1, 1, 8'h99);
        repeat (6) step(1, 1, 1, 0, '0);
        step(1, 0, 0, 1, 8'h00);
        repeat (6) step(1, 1, 0, 0, '0);
        step(1, 0, 1, 1, 8'h10);
        repeat (3) step(1, 1, 1, 0, '0);
        step(1, 1, 1, 1, 8'h42);
        repeat (5) step(1, 1, 1, 0, '0);
        step(1, 0, 1, 1, 8'hA7);
        step(1, 0, 1, 1, 8'h35);
        repeat (10) step(1, 0, 1, 0, '0);
        step(1, 0, 1, 1, 8'h57);
        repeat (3) step(1, 1, 1, 0, '0);
        step(0, 1, 1, 1, 8'h33);
        step(1, 0, 1, 1, 8'h0F);
        repeat (5) step(1, 1, 1, 0, '0);
        step(1, 0, 1, 1, 8'hFF);
        repeat (5) step(1, 1, 1, 0, '0);
        repeat (3000)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 19) == 0, 8'($urandom));
        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan_counter.md
# sevenseg_scan_counter

Parametrised successor to the single-digit counter/decoder pair: a multi-digit up/down counter with a load port, a tick prescaler and a time-multiplexed seven-segment scan driver. It sits in the user project between the GPIO pads and an external common-segment LED display. One shared 7-bit segment bus plus a one-hot digit-select bus drive up to 8 digits. It is a drop-in replacement for the counter/segment pair in the top-level wrapper.

## Interface
- DIGITS, 4, number of digits (1..8); value is 4*DIGITS bits, one nibble per digit, digit 0 least significant
- PRESCALE, 4, clk cycles per count tick while enabled (>=1; 1 = tick every enabled cycle)
- SCAN_DIV, 64, clk cycles each digit stays selected (>=1)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- en  in  1  count enable; prescaler and counter hold when 0
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous load strobe
- load_val  in  4*DIGITS  value loaded on load
- value  out  4*DIGITS  current count, registered
- wrap  out  1  one-cycle pulse when the count wraps
- segments  out  7  glyph of the selected digit, bits [6:0] = g..a, active-high, registered
- digit_sel  out  DIGITS  one-hot digit enable, bit i = digit i, registered

## Operation
- Prescaler pre_cnt counts 0..PRESCALE-1 while en=1 and holds while en=0. tick = en && pre_cnt==PRESCALE-1; pre_cnt returns to 0 on tick.
- On tick the counter steps by 1 in the selected direction, per digit radix R (10, or 16 with HEX), with carry/borrow rippling within the same cycle.
- Up: a digit at R-1 goes to 0 and carries. All digits at R-1 -> all 0, and wrap=1 for one cycle.
- Down: a digit at 0 goes to R-1 and borrows. All digits 0 -> all R-1, and wrap=1.
- load has priority over tick. On load: value <= load_val, pre_cnt <= 0, wrap=0. In decimal mode any nibble >9 is saturated to 9 at load.
- `up` may change at any cycle; it is sampled on the tick cycle only.
- Scan: scan_cnt counts 0..SCAN_DIV-1 continuously, independent of en. On SCAN_DIV-1, idx advances, wrapping DIGITS-1 -> 0.
- Every cycle: digit_sel <= 1<<idx and segments <= glyph(value nibble idx).
- Glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Any nibble without a glyph maps to 00 (blank).

## Timing
- Reset values: value=0, wrap=0, pre_cnt=0, scan_cnt=0, idx=0, digit_sel=1 (digit 0), segments=3F.
- Reset has priority over load, tick and scan, and takes effect on the first rising edge with rstn=0, including mid-count and mid-scan.
- value and wrap update on the edge ending the tick or load cycle.
- segments/digit_sel lag idx/value by exactly one cycle. A new value on the selected digit appears on segments one edge after value changes.
- digit_sel and segments switch on the same edge, so there is never a mismatched glyph/digit pair.
- DIGITS=1: idx stays 0 and digit_sel stays 1.
- SCAN_DIV=1: idx advances every cycle.

## Configuration
- SEVENSEG_HEX_EN defined: radix 16 per digit, load_val nibbles taken unmodified, extra glyphs A=77 b=7C C=39 d=5E E=79 F=71. Wrap occurs at all-F (up) and all-0 (down).
- Undefined: radix 10 as described, load saturation active, nibble values 10..15 never appear on value.

## Test plan
Bench parameters are DIGITS=2, PRESCALE=4, SCAN_DIV=2 unless stated.
- Reset, then hold en=1, up=1 for 40 cycles -> value=0x10 after 40 cycles (10 ticks). Digit 0 goes 9 -> 0 with carry. wrap stays 0.
- load 0x99, then one tick up -> value=0x00, wrap high for exactly one cycle. Next load 0x00 with up=0, one tick -> value=0x99, wrap pulse.
- load and tick asserted in the same cycle with load_val=0x42 -> value=0x42, pre_cnt=0, next tick after 4 cycles gives 0x43. Decimal build: load 0xA7 -> value=0x97.
- Scan check, value=0x35 held -> digit_sel alternates 01,01,10,10,… with segments 6D while digit_sel=01 and 4F while digit_sel=10, never mismatched.
- rstn low mid-count, e.g. value=0x57 with scan on digit 1 -> next edge value=0x00, digit_sel=01, segments=3F, wrap=0.
- SEVENSEG_HEX_EN build: load 0x0F, one tick up -> 0x10. Load 0xFF, one tick up -> 0x00 with wrap. Digit showing F -> segments=71.
